e_demux_route: RTL and testbench
================================

# e_demux_route

Registered 1-to-P demultiplexer with valid/ready flow control: the receive-side counterpart of the crossbar's P-to-1 select path. One input stream carries data plus a destination select. Each word is steered into a one-entry output slot for the selected port and held until that port accepts it. Sits on the crossbar's distribution side, fanning a single source out to P independent sinks.

## Interface
- P, 4, number of output ports (crossbar port count)
- S, 2, select width; P <= 2**S
- W, 8, data width per port
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  W  word to route
- in_sel  input  S  destination port index
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  block accepts the word this cycle
- out_data  output  P*W  port k occupies bits [k*W +: W]
- out_valid  output  P  slot k holds a word
- out_ready  input  P  sink k accepts slot k
- drop_err  output  1  one-cycle pulse: word with in_sel >= P was discarded
- stat_cnt  output  P*8  per-port delivery counters (only with E_DEMUX_STAT_EN)

## Operation
- Each port slot is a 2-state FSM:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain (out_valid & out_ready) with no load.
  - FULL stays FULL on simultaneous drain and load; the new word replaces the old one.
- Routing readiness:
  - in_sel < P: in_ready = !out_valid[in_sel] | out_ready[in_sel]. Combinational; no dependence on in_valid.
  - in_sel >= P: in_ready = 1.
- A transfer occurs when in_valid & in_ready.
  - In-range transfer: slot in_sel loads in_data.
  - Out-of-range transfer: the word is discarded and drop_err pulses.
- Only the selected slot loads. All other slots are unaffected.
- While FULL and not drained, out_data[k] stays stable and out_valid[k] stays high.
- out_data of an EMPTY slot holds its last value. Sinks ignore it.

## Timing
- Latency is 1 cycle: a word accepted at edge n appears at out_valid/out_data from edge n.
- drop_err is registered: high for exactly the one cycle after an out-of-range transfer.
- Full throughput: one word per cycle to one port, provided that sink holds out_ready high.
- Back-to-back words to different ports each take one cycle. Blocking on one port never blocks the others.
- Reset (asynchronous, any time, including mid-transfer):
  - out_valid = 0, out_data = 0, drop_err = 0, stat_cnt = 0.
  - The in-flight word is lost.
  - in_ready is valid combinationally as soon as rst deasserts.

## Configuration
- E_DEMUX_STAT_EN defined:
  - Per-port 8-bit counter increments on each drain (out_valid[k] & out_ready[k]).
  - Counters saturate at 255 (no wrap). They clear only on rst.
  - Values are exposed on stat_cnt.
- E_DEMUX_STAT_EN undefined: stat_cnt port and counters are absent; no other behaviour changes.

## Structure
- Package e_route_pkg holds:
  - default port count, select width and data width constants;
  - the slot state encoding (EMPTY = 0, FULL = 1);
  - counter width (8) and saturation value.
- One sub-module, e_demux_slot, instantiated P times. Each instance contains:
  - the data register and valid flop;
  - load/drain logic;
  - the optional saturating counter.
- The top level contains only select decode, in_ready mux and drop_err.

## Test plan
- Single route:
  - Stimulus: in_sel=2, in_data=0xA5, in_valid for 1 cycle, out_ready=4'b1111.
  - Response: out_valid=4'b0100 for exactly 1 cycle with out_data[23:16]=0xA5; other slots stay EMPTY.
- Backpressure:
  - Stimulus: out_ready[1]=0; send 0x11 then 0x22, both to port 1.
  - Response: in_ready drops after the first word; slot 1 holds 0x11. Raising out_ready[1] drains 0x11, and 0x22 loads that same cycle with out_valid[1] staying 1.
- Independence:
  - Stimulus: port 0 blocked and FULL; send words to ports 3, 2, 1 on consecutive cycles.
  - Response: all three are accepted with no stalls and each appears 1 cycle after acceptance.
- Out-of-range:
  - Stimulus: P=3, S=2, in_sel=3, in_data=0x7E.
  - Response: in_ready=1, drop_err high for 1 cycle, and no out_valid bit rises.
- Reset mid-operation:
  - Stimulus: all four slots FULL; pulse rst asynchronously between edges.
  - Response: out_valid=0, out_data=0 and drop_err=0 immediately; the first word after rst deasserts is routed normally.
- Stats (with E_DEMUX_STAT_EN):
  - Stimulus: 300 drains on port 0.
  - Response: stat_cnt[7:0]=255; the other counters are 0.

Source files
------------

// File: rtl/e_demux_route_pkg.sv
// Shared constants and slot state encoding for the e_demux_route slice.
// E_DEMUX_STAT_EN (optional) adds per-port saturating delivery counters.
package e_route_pkg;

    localparam int DEF_P = 4;
    localparam int DEF_S = 2;
    localparam int DEF_W = 8;

    localparam int                 CNT_W   = 8;
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/e_demux_route_if.sv
// Input stream plus P output slots of the 1-to-P demultiplexer.
// stat_cnt exists only when E_DEMUX_STAT_EN is defined.
interface e_demux_route_if
    import e_route_pkg::*;
#(
    parameter int P = DEF_P,
    parameter int S = DEF_S,
    parameter int W = DEF_W
);

    logic [W-1:0]       in_data;
    logic [S-1:0]       in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [P*W-1:0]     out_data;
    logic [P-1:0]       out_valid;
    logic [P-1:0]       out_ready;
    logic               drop_err;
`ifdef E_DEMUX_STAT_EN
    logic [P*CNT_W-1:0] stat_cnt;
`endif

    modport master (
        output in_data, in_sel, in_valid, out_ready,
`ifdef E_DEMUX_STAT_EN
        input  stat_cnt,
`endif
        input  in_ready, out_data, out_valid, drop_err
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
`ifdef E_DEMUX_STAT_EN
        output stat_cnt,
`endif
        output in_ready, out_data, out_valid, drop_err
    );

endinterface

// File: rtl/e_demux_route_slot.sv
// One-entry output slot: data register, EMPTY/FULL state and optional
// saturating delivery counter (E_DEMUX_STAT_EN).
module e_demux_slot
    import e_route_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     din,
    input  logic             ready,
    output logic             valid,
    output logic [W-1:0]     data
`ifdef E_DEMUX_STAT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    slot_state_e  state, state_next;
    logic [W-1:0] data_q;
    logic         drain;

    assign valid = (state == FULL);
    assign drain = valid & ready;
    assign data  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // A load into a FULL slot only happens alongside a drain, so the new word replaces the old.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (load)           state_next = FULL;
            FULL:    if (drain && !load) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       data_q <= '0;
        else if (load) data_q <= din;
    end

`ifdef E_DEMUX_STAT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          cnt_q <= '0;
        else if (drain && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
    end

    assign cnt = cnt_q;
`endif

endmodule

// File: rtl/e_demux_route.sv
// Registered 1-to-P demultiplexer: select decode, in_ready mux and drop_err;
// per-port storage lives in e_demux_slot. Optional feature: E_DEMUX_STAT_EN.
module e_demux_route
    import e_route_pkg::*;
#(
    parameter int P = DEF_P,
    parameter int S = DEF_S,
    parameter int W = DEF_W
) (
    input logic             clk,
    input logic             rst,
    e_demux_route_if.slave  bus
);

    logic [P-1:0]       hit;
    logic [P-1:0]       load;
    logic               slot_ready;
    logic               in_range;
    logic               drop_q;
    logic [P-1:0]       valid_v;
    logic [P*W-1:0]     data_v;

    // Out-of-range selects hit no slot and are always accepted (then discarded).
    always_comb begin
        hit        = '0;
        slot_ready = 1'b0;
        for (int unsigned k = 0; k < P; k++) begin
            if (bus.in_sel == S'(k)) begin
                hit[k]     = 1'b1;
                slot_ready = !valid_v[k] | bus.out_ready[k];
            end
        end
    end

    assign in_range     = |hit;
    assign bus.in_ready = in_range ? slot_ready : 1'b1;
    assign load         = hit & {P{bus.in_valid & slot_ready}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_q <= 1'b0;
        else     drop_q <= bus.in_valid & !in_range;
    end

    assign bus.drop_err  = drop_q;
    assign bus.out_valid = valid_v;
    assign bus.out_data  = data_v;

`ifdef E_DEMUX_STAT_EN
    logic [P*CNT_W-1:0] cnt_v;
    assign bus.stat_cnt = cnt_v;
`endif

    for (genvar k = 0; k < P; k++) begin : g_slot
        e_demux_slot #(
            .W(W)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[k]),
            .din   (bus.in_data),
            .ready (bus.out_ready[k]),
            .valid (valid_v[k]),
            .data  (data_v[k*W +: W])
`ifdef E_DEMUX_STAT_EN
            ,
            .cnt   (cnt_v[k*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_e_demux_route.sv
// Directed bench for e_demux_route: vector table on a P=4 instance plus
// hand sequences for out-of-range (P=3), async reset and counters.
module tb_e_demux_route;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #10 clk = ~clk;

    e_demux_route_if #(.P(4), .S(2), .W(8)) bus4 ();
    e_demux_route_if #(.P(3), .S(2), .W(8)) bus3 ();

    e_demux_route #(.P(4), .S(2), .W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    e_demux_route #(.P(3), .S(2), .W(8)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [7:0]  d;
        logic [3:0]  ordy;
        logic        e_rdy;
        logic [3:0]  e_ov;
        logic [31:0] e_od;
        logic        e_drop;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive4(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic [3:0] ordy);
        bus4.in_valid  = v;
        bus4.in_sel    = sel;
        bus4.in_data   = d;
        bus4.out_ready = ordy;
    endtask

    task automatic drive3(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic [2:0] ordy);
        bus3.in_valid  = v;
        bus3.in_sel    = sel;
        bus3.in_data   = d;
        bus3.out_ready = ordy;
    endtask

    initial begin
        // Expected outputs are the state left by the preceding vectors.
        vecs[0]  = '{1'b1, 2'd2, 8'hA5, 4'b1111, 1'b1, 4'b0000, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0100, 32'h00A50000, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h00A50000, 1'b0};
        vecs[3]  = '{1'b1, 2'd1, 8'h11, 4'b1101, 1'b1, 4'b0000, 32'h00A50000, 1'b0};
        vecs[4]  = '{1'b1, 2'd1, 8'h22, 4'b1101, 1'b0, 4'b0010, 32'h00A51100, 1'b0};
        vecs[5]  = '{1'b1, 2'd1, 8'h22, 4'b1111, 1'b1, 4'b0010, 32'h00A51100, 1'b0};
        vecs[6]  = '{1'b0, 2'd1, 8'h00, 4'b1101, 1'b0, 4'b0010, 32'h00A52200, 1'b0};
        vecs[7]  = '{1'b1, 2'd0, 8'h5A, 4'b1100, 1'b1, 4'b0010, 32'h00A52200, 1'b0};
        vecs[8]  = '{1'b1, 2'd3, 8'h33, 4'b1100, 1'b1, 4'b0011, 32'h00A5225A, 1'b0};
        vecs[9]  = '{1'b1, 2'd2, 8'h44, 4'b0000, 1'b1, 4'b1011, 32'h33A5225A, 1'b0};
        vecs[10] = '{1'b1, 2'd1, 8'h55, 4'b0010, 1'b1, 4'b1111, 32'h3344225A, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 4'b1111, 32'h3344555A, 1'b0};
        vecs[12] = '{1'b1, 2'd0, 8'h66, 4'b0000, 1'b0, 4'b1111, 32'h3344555A, 1'b0};
        vecs[13] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b1111, 32'h3344555A, 1'b0};
        vecs[14] = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0000, 32'h3344555A, 1'b0};

        drive4(1'b0, 2'd0, 8'h00, 4'b0000);
        drive3(1'b0, 2'd0, 8'h00, 3'b000);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ov4", 32'(bus4.out_valid), 32'h0);
        chk("rst_od4", bus4.out_data, 32'h0);
        chk("rst_drop4", 32'(bus4.drop_err), 32'h0);
        chk("rst_ov3", 32'(bus3.out_valid), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            drive4(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].ordy);
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), 32'(bus4.in_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_out_valid", i), 32'(bus4.out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_out_data", i), bus4.out_data, vecs[i].e_od);
            chk($sformatf("v%0d_drop_err", i), 32'(bus4.drop_err), 32'(vecs[i].e_drop));
        end

        // Out-of-range on the P=3 instance
        @(posedge clk); #1;
        drive3(1'b1, 2'd3, 8'h7E, 3'b111);
        @(negedge clk);
        chk("oor_in_ready", 32'(bus3.in_ready), 32'h1);
        @(posedge clk); #1;
        drive3(1'b0, 2'd0, 8'h00, 3'b111);
        @(negedge clk);
        chk("oor_drop_high", 32'(bus3.drop_err), 32'h1);
        chk("oor_no_valid", 32'(bus3.out_valid), 32'h0);
        @(posedge clk); #1;
        drive3(1'b1, 2'd2, 8'h3C, 3'b111);
        @(negedge clk);
        chk("oor_drop_once", 32'(bus3.drop_err), 32'h0);
        chk("oor_still_no_valid", 32'(bus3.out_valid), 32'h0);
        @(posedge clk); #1;
        drive3(1'b0, 2'd0, 8'h00, 3'b000);
        @(negedge clk);
        chk("p3_inrange_valid", 32'(bus3.out_valid), 32'h4);
        chk("p3_inrange_data", 32'(bus3.out_data), 32'h3C0000);
        chk("p3_inrange_nodrop", 32'(bus3.drop_err), 32'h0);

        // Fill all four slots, leave drop_err high on dut3, then async reset between edges
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            drive4(1'b1, 2'(k), 8'(k + 1), 4'b0000);
            if (k == 3) drive3(1'b1, 2'd3, 8'h7E, 3'b000);
        end
        @(posedge clk); #1;
        drive4(1'b0, 2'd0, 8'h00, 4'b0000);
        drive3(1'b0, 2'd0, 8'h00, 3'b000);
        chk("pre_rst_ov4", 32'(bus4.out_valid), 32'hF);
        chk("pre_rst_od4", bus4.out_data, 32'h04030201);
        chk("pre_rst_drop3", 32'(bus3.drop_err), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ov4", 32'(bus4.out_valid), 32'h0);
        chk("async_rst_od4", bus4.out_data, 32'h0);
        chk("async_rst_drop3", 32'(bus3.drop_err), 32'h0);
        #1 rst = 1'b0;
        #1;
        drive4(1'b1, 2'd1, 8'h99, 4'b1111);
        #1;
        chk("post_rst_in_ready", 32'(bus4.in_ready), 32'h1);
        @(posedge clk); #1;
        drive4(1'b0, 2'd0, 8'h00, 4'b0000);
        @(negedge clk);
        chk("post_rst_ov4", 32'(bus4.out_valid), 32'h2);
        chk("post_rst_od4", bus4.out_data, 32'h00009900);

`ifdef E_DEMUX_STAT_EN
        @(posedge clk); #3 rst = 1'b1;
        #2 rst = 1'b0;
        chk("stat_rst", bus4.stat_cnt, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive4(1'b1, 2'd0, 8'(i), 4'b0001);
        end
        @(posedge clk); #1;
        drive4(1'b0, 2'd0, 8'h00, 4'b0000);
        @(negedge clk);
        chk("stat_nine", bus4.stat_cnt, 32'h00000009);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            drive4(1'b1, 2'd0, 8'(i), 4'b0001);
        end
        @(posedge clk); #1;
        drive4(1'b0, 2'd0, 8'h00, 4'b0001);
        repeat (2) @(negedge clk);
        chk("stat_saturate", bus4.stat_cnt, 32'h000000FF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
